// File: rtl/taiga_config.sv
// Global configuration constants for the Taiga-style core slice.
package taiga_config;

  localparam int unsigned XLEN = 32;

endpackage

// File: rtl/taiga_types.sv
// Shared types for the writeback path: thread ids and the result packet.
package taiga_types;
  import taiga_config::*;

  localparam int unsigned NUM_THREADS = 4;

  typedef logic [1:0] thread_id_t;

  typedef struct packed {
    thread_id_t            thread;
    logic [4:0]            rd;
    logic [XLEN-1:0]       data;
  } wb_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, scan starts at an
// internal pointer that moves just past the winner whenever advance is high.
module rr_arbiter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] request,
  input  logic             advance,
  output logic [WIDTH-1:0] grant
);

  localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic             found;

  // First pass covers requesters at or above the pointer, second pass wraps.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && (PTR_W'(i) >= ptr_q) && request[i]) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (!found && request[i]) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == PTR_W'(WIDTH - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Selects one functional-unit result per cycle for the register file and
// tracks per-thread pending destinations in a scoreboard.
module writeback_arbiter
  import taiga_config::*;
  import taiga_types::*;
#(
  parameter int unsigned NUM_WB_UNITS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_WB_UNITS-1:0]             wb_valid,
  output logic [NUM_WB_UNITS-1:0]             wb_ready,
  input  logic [NUM_WB_UNITS-1:0][1:0]        wb_thread,
  input  logic [NUM_WB_UNITS-1:0][4:0]        wb_rd,
  input  logic [NUM_WB_UNITS-1:0][XLEN-1:0]   wb_data,
  output logic                                wr_en,
  output logic [1:0]                          thread_rd_id,
  output logic [4:0]                          rd_addr,
  output logic [XLEN-1:0]                     new_data,
  input  logic                                issue_en,
  input  logic [1:0]                          issue_thread,
  input  logic [4:0]                          issue_rd,
  input  logic [1:0]                          query_thread,
  input  logic [4:0]                          query_rs1,
  input  logic [4:0]                          query_rs2,
  output logic                                rs1_pending,
  output logic                                rs2_pending
);

  logic [NUM_WB_UNITS-1:0]        grant;
  logic                           accept;
  wb_packet_t                     sel;

  logic                           wr_en_q;
  thread_id_t                     thread_q;
  logic [4:0]                     rd_q;
  logic [XLEN-1:0]                data_q;

  logic [NUM_THREADS-1:0][31:0]   pending_q;
  logic [NUM_THREADS-1:0][31:0]   pending_d;

  rr_arbiter #(
    .WIDTH   (NUM_WB_UNITS)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .request (wb_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Reset blocks the handshake so any in-flight result is dropped.
  assign wb_ready = rst ? '0 : grant;
  assign accept   = |(wb_valid & wb_ready);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_WB_UNITS; i++) begin
      if (grant[i]) begin
        sel.thread = wb_thread[i];
        sel.rd     = wb_rd[i];
        sel.data   = wb_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      thread_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      wr_en_q <= accept && (sel.rd != 5'd0);
      if (accept) begin
        thread_q <= sel.thread;
        rd_q     <= sel.rd;
        data_q   <= sel.data;
      end
    end
  end

  assign wr_en        = wr_en_q;
  assign thread_rd_id = thread_q;
  assign rd_addr      = rd_q;
  assign new_data     = data_q;

  // Set is applied after clear so a same-cycle issue keeps the bit pending.
  always_comb begin
    pending_d = pending_q;
    if (accept) begin
      pending_d[sel.thread][sel.rd] = 1'b0;
    end
    if (issue_en && (issue_rd != 5'd0)) begin
      pending_d[issue_thread][issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign rs1_pending = (query_rs1 != 5'd0) && pending_q[query_thread][query_rs1];
  assign rs2_pending = (query_rs2 != 5'd0) && pending_q[query_thread][query_rs2];

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_WB_UNITS, default 3, meaning the number of functional-unit result ports.
REQ-002 SHALL take XLEN from taiga_config (32), meaning the data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-005 SHALL have port wb_valid, input, NUM_WB_UNITS, per-unit result valid.
REQ-006 SHALL have port wb_ready, output, NUM_WB_UNITS, per-unit result accepted this cycle.
REQ-007 SHALL have port wb_thread, input, NUM_WB_UNITS x 2, per-unit destination thread id.
REQ-008 SHALL have port wb_rd, input, NUM_WB_UNITS x 5, per-unit destination register.
REQ-009 SHALL have port wb_data, input, NUM_WB_UNITS x XLEN, per-unit result data.
REQ-010 SHALL have port wr_en, output, 1, register-file write strobe.
REQ-011 SHALL have port thread_rd_id, output, 2, register-file write thread.
REQ-012 SHALL have port rd_addr, output, 5, register-file write register.
REQ-013 SHALL have port new_data, output, XLEN, register-file write data.
REQ-014 SHALL have port issue_en, input, 1, an instruction with a destination was issued.
REQ-015 SHALL have ports issue_thread (input, 2) and issue_rd (input, 5), the issued destination.
REQ-016 SHALL have ports query_thread (input, 2), query_rs1 (input, 5) and query_rs2 (input, 5), the operand lookup.
REQ-017 SHALL have ports rs1_pending and rs2_pending, output, 1 each, operand awaiting writeback.

Function
REQ-018 SHALL accept at most one result per cycle; unit i is accepted when wb_valid[i] and wb_ready[i] are both high.
REQ-019 SHALL raise wb_ready combinationally, only for the unit granted by round-robin among the valid units; it is never raised for an invalid unit.
REQ-020 SHALL start the round-robin scan at the priority pointer, then move the pointer to (granted+1) mod NUM_WB_UNITS after each accept; with no accept the pointer holds.
REQ-021 SHALL register an accepted result onto wr_en/thread_rd_id/rd_addr/new_data on the next edge: latency 1 cycle, back-to-back every cycle.
REQ-022 SHALL hold wr_en low in any cycle following no accept; the data outputs then hold their last value.
REQ-023 SHALL still accept (ready high) a result with wb_rd==0 but keep wr_en low for it, so x0 is never written.
REQ-024 SHALL keep a 4x32 pending scoreboard: bit [issue_thread][issue_rd] is set on issue_en, and ignored when issue_rd==0.
REQ-025 SHALL clear scoreboard bit [wb_thread][wb_rd] on the edge that accepts that result.
REQ-026 SHALL let set win over clear when the same bit is set and cleared in the same cycle.
REQ-027 SHALL drive rs1_pending = scoreboard[query_thread][query_rs1] (rs2 likewise) combinationally, forced to 0 for register 0.
REQ-028 SHALL NOT bypass: a clear takes effect on the query one cycle after the accept.

Reset
REQ-029 SHALL, while rst is high at the edge, set wr_en=0, thread_rd_id=0, rd_addr=0, new_data=0, priority pointer=0 and all scoreboard bits=0.
REQ-030 SHALL force wb_ready=0 during reset; a result in flight when reset is asserted is dropped.

Structure
REQ-031 SHALL place thread_id_t (2-bit), NUM_THREADS=4 and the wb_packet_t struct {thread, rd, data} in taiga_types.
REQ-032 SHALL implement grant selection in a sub-module rr_arbiter, parameterized by width, taking request/advance and returning a one-hot grant.

Verification
REQ-033 SHALL cover: unit0 valid, thread 2, rd 5, data 0xDEADBEEF -> next cycle wr_en=1, thread_rd_id=2, rd_addr=5, new_data=0xDEADBEEF.
REQ-034 SHALL cover: all 3 units valid for 6 cycles -> grants 0,1,2,0,1,2 and wr_en high for 6 consecutive cycles.
REQ-035 SHALL cover: unit1 result with rd 0 -> wb_ready[1]=1 and wr_en stays 0 the next cycle.
REQ-036 SHALL cover: issue thread 1, rd 7; query thread 1, rs1 7 -> rs1_pending=1; accept result for thread 1, rd 7 -> rs1_pending=0 one cycle later.
REQ-037 SHALL cover: issue and accept on thread 3, rd 9 in the same cycle -> the bit stays set.
REQ-038 SHALL cover: rst asserted mid-stream with 2 units valid -> wr_en=0 and wb_ready=0 during reset, all pending=0, and the first grant after reset goes to unit 0.
